// File: rtl/dram_cmd_scheduler.sv
// DRAM command scheduler: turns single L2 read/write requests into
// PRE/ACT/RW command sequences under an open-page policy. It also
// interleaves refresh as a PRE-all/REF pair between requests.
module dram_cmd_scheduler #(
    parameter  int NUM_OF_BANKS = 8,
    parameter  int ROW_W        = 7,
    parameter  int COL_W        = 3,
    localparam int BANK_W       = (NUM_OF_BANKS > 1) ? $clog2(NUM_OF_BANKS) : 1
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_val,
    output logic              req_rdy,
    input  logic              req_rw,
    input  logic [BANK_W-1:0] req_bank,
    input  logic [ROW_W-1:0]  req_row,
    input  logic [COL_W-1:0]  req_col,
    input  logic              refresh_req,
    output logic              refresh_ack,
    output logic              cmd_req,
    input  logic              cmd_ack,
    output logic [1:0]        cmd,
    output logic [BANK_W-1:0] cmd_bank,
    output logic [ROW_W-1:0]  cmd_row,
    output logic [COL_W-1:0]  cmd_col,
    output logic              cmd_rw,
    output logic              cmd_all
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PRE  = 3'd1;
    localparam logic [2:0] S_ACT  = 3'd2;
    localparam logic [2:0] S_RW   = 3'd3;
    localparam logic [2:0] S_PREA = 3'd4;
    localparam logic [2:0] S_REF  = 3'd5;

    localparam logic [1:0] C_PRE = 2'b00;
    localparam logic [1:0] C_ACT = 2'b01;
    localparam logic [1:0] C_RW  = 2'b10;
    localparam logic [1:0] C_REF = 2'b11;

    logic [2:0]              r_state;
    logic [2:0]              w_state_nxt;
    logic                    r_rw;
    logic [BANK_W-1:0]       r_bank;
    logic [ROW_W-1:0]        r_row;
    logic [COL_W-1:0]        r_col;
    logic [NUM_OF_BANKS-1:0] r_open;
    logic [ROW_W-1:0]        r_open_row [NUM_OF_BANKS];
    logic                    r_ref_pend;
    logic                    r_refresh_ack;
    logic                    w_refresh;
    logic                    w_accept;
    logic                    w_ack;

    // A raw refresh_req counts as pending in the same cycle, so refresh beats req_val.
    assign w_refresh   = r_ref_pend | refresh_req;
    assign req_rdy     = (r_state == S_IDLE) & ~w_refresh;
    assign w_accept    = req_val & req_rdy;
    // Every non-idle state issues a command, so cmd_req follows directly from the state.
    assign cmd_req     = (r_state != S_IDLE);
    assign w_ack       = cmd_req & cmd_ack;
    assign refresh_ack = r_refresh_ack;

    // Next-state selection: page hit/miss/closed on accept, refresh sequencing, ack-driven advance
    always_comb begin
        // NOTE: default first so every path assigns and no latch is inferred.
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_refresh) begin
                    w_state_nxt = (|r_open) ? S_PREA : S_REF;
                end else if (req_val) begin
                    if (!r_open[req_bank])                       w_state_nxt = S_ACT;
                    else if (r_open_row[req_bank] == req_row)    w_state_nxt = S_RW;
                    else                                         w_state_nxt = S_PRE;
                end
            end
            S_PRE:   if (w_ack) w_state_nxt = S_ACT;
            S_ACT:   if (w_ack) w_state_nxt = S_RW;
            S_RW:    if (w_ack) w_state_nxt = S_IDLE;
            S_PREA:  if (w_ack) w_state_nxt = S_REF;
            S_REF:   if (w_ack) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, request latch, open-bank flags and refresh bookkeeping
    always_ff @(posedge clk or negedge rst_b) begin
        // NOTE: sequential state uses non-blocking assignments only, so every read sees pre-edge values.
        if (!rst_b) begin
            r_state       <= S_IDLE;
            r_rw          <= 1'b0;
            r_bank        <= '0;
            r_row         <= '0;
            r_col         <= '0;
            r_open        <= '0;
            r_ref_pend    <= 1'b0;
            r_refresh_ack <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_rw   <= req_rw;
                r_bank <= req_bank;
                r_row  <= req_row;
                r_col  <= req_col;
            end
            if (w_ack) begin
                case (r_state)
                    S_PRE:   r_open[r_bank] <= 1'b0;
                    S_ACT:   r_open[r_bank] <= 1'b1;
                    S_PREA:  r_open         <= '0;
                    default: ;
                endcase
            end
            // A new refresh request on the REF-ack edge wins, leaving another refresh pending.
            if (refresh_req)                          r_ref_pend <= 1'b1;
            else if (w_ack && (r_state == S_REF))     r_ref_pend <= 1'b0;
            r_refresh_ack <= w_ack && (r_state == S_REF);
        end
    end

    // Open-row store, written when an ACT is accepted
    always_ff @(posedge clk) begin
        // NOTE: row storage is not reset; it is only meaningful while the bank's open flag is set.
        if (w_ack && (r_state == S_ACT)) r_open_row[r_bank] <= r_row;
    end

    // Command fields decoded from state; fields unused by a command stay zero
    always_comb begin
        cmd      = C_PRE;
        cmd_bank = '0;
        cmd_row  = '0;
        cmd_col  = '0;
        cmd_rw   = 1'b0;
        cmd_all  = 1'b0;
        case (r_state)
            S_PRE: begin
                cmd      = C_PRE;
                cmd_bank = r_bank;
            end
            S_ACT: begin
                cmd      = C_ACT;
                cmd_bank = r_bank;
                cmd_row  = r_row;
            end
            S_RW: begin
                cmd      = C_RW;
                cmd_bank = r_bank;
                cmd_col  = r_col;
                cmd_rw   = r_rw;
            end
            S_PREA: begin
                cmd      = C_PRE;
                cmd_all  = 1'b1;
            end
            S_REF:   cmd = C_REF;
            default: ;
        endcase
    end

endmodule

// File: doc/dram_cmd_scheduler.md
DRAM_CMD_SCHEDULER -- requirements
Module: dram_cmd_scheduler

Interface
REQ-001 SHALL have parameters: NUM_OF_BANKS, default 8, bank count; ROW_W, default 7, row-address bits; COL_W, default 3, column-address bits.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_b  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req_val  input  1  L2 request valid.
REQ-005 SHALL have port req_rdy  output  1  scheduler accepts request this cycle.
REQ-006 SHALL have port req_rw  input  1  request type, 1=write, 0=read.
REQ-007 SHALL have port req_bank  input  log2(NUM_OF_BANKS)  target bank.
REQ-008 SHALL have port req_row  input  ROW_W  target row.
REQ-009 SHALL have port req_col  input  COL_W  target column.
REQ-010 SHALL have port refresh_req  input  1  refresh request pulse from refresh counter.
REQ-011 SHALL have port refresh_ack  output  1  one-cycle pulse on refresh completion.
REQ-012 SHALL have port cmd_req  output  1  command valid to DRAM array.
REQ-013 SHALL have port cmd_ack  input  1  DRAM array accepts command.
REQ-014 SHALL have port cmd  output  2  00=PRE, 01=ACT, 10=RW, 11=REF.
REQ-015 SHALL have ports cmd_bank, cmd_row, cmd_col  output  bank/ROW_W/COL_W  command address; cmd_rw  output  1  write qualifier for RW; cmd_all  output  1  precharge-all qualifier for PRE.

Function
REQ-016 SHALL implement states IDLE, PRE, ACT, RW, PREA, REF.
REQ-017 SHALL hold per-bank open flag and open-row register; all flags clear after reset.
REQ-018 SHALL drive req_rdy = (state==IDLE) & ~ref_pend & ~refresh_req, combinationally.
REQ-019 SHALL latch req_rw/bank/row/col on req_val & req_rdy (cycle T); cmd_req SHALL be high at T+1.
REQ-020 From IDLE on accept: bank open and row equal -> RW; bank open and row differs -> PRE; bank closed -> ACT.
REQ-021 Command handshake: cmd_req and all cmd_* fields held stable until cmd_ack sampled high; on that edge the state advances and cmd_req deasserts unless the next state issues a command, in which case cmd_req stays high with new fields the following cycle.
REQ-022 cmd_ack while cmd_req low SHALL be ignored.
REQ-023 PRE ack -> clear bank open flag -> ACT; ACT ack -> set open flag, store row -> RW; RW ack -> IDLE; bank left open after RW (open-page policy).
REQ-024 refresh_req SHALL set ref_pend (sticky); refresh_req during a sequence SHALL not abort it.
REQ-025 In IDLE with ref_pend set (or refresh_req high): any bank open -> PREA (cmd=PRE, cmd_all=1); none open -> REF directly; refresh SHALL beat a simultaneous req_val.
REQ-026 PREA ack -> clear all open flags -> REF; REF ack -> clear ref_pend, pulse refresh_ack one cycle, -> IDLE.
REQ-027 refresh_req arriving in the same cycle as REF ack SHALL leave ref_pend set (new refresh pending).
REQ-028 cmd_rw SHALL equal latched req_rw in RW, 0 otherwise; cmd_all SHALL be 1 only in PREA; unused address fields SHALL be 0.

Reset
REQ-029 On rst_b low, immediately: state=IDLE, cmd_req=0, cmd=00, cmd_bank/row/col=0, cmd_rw=0, cmd_all=0, refresh_ack=0, ref_pend=0, all open flags=0; req_rdy=1 once rst_b high with no refresh_req.
REQ-030 Reset mid-handshake SHALL abandon the command with no further cmd_req until a new accept.

Verification
REQ-031 After reset, read bank 2 row 5 col 3, cmd_ack each cycle -> ACT(b2,r5) at T+1, RW(b2,c3,rw=0) at T+2, req_rdy high at T+3.
REQ-032 Then write bank 2 row 5 col 1 -> single RW(b2,c1,rw=1), no ACT.
REQ-033 Then read bank 2 row 9 -> PRE(b2), ACT(b2,r9), RW in order; cmd held stable across 3 cycles of cmd_ack=0.
REQ-034 refresh_req and req_val same IDLE cycle with bank 2 open -> req_rdy=0, PRE cmd_all=1, REF, refresh_ack pulse, then request served starting ACT.
REQ-035 refresh_req during ACT wait -> ACT and RW complete first, then REF (no PREA if only... PREA issued since bank now open).
REQ-036 rst_b low while cmd_req=1 awaiting ack -> cmd_req=0 same cycle, open flags cleared, next read to same row issues ACT.
